// File: rtl/sensor_cmd_seq.sv
// sensor_cmd_seq: start/stop command frame sequencer feeding a UART transmitter
// Build option: define SENSOR_CMD_CHKSUM_EN to append an XOR checksum word to each frame.
// Ports:
//   Clk            system clock
//   Rst_n          asynchronous active-low reset
//   Sys_Start      requested run level (asynchronous, synchronised internally)
//   Tx_Done        UART word-complete pulse, honoured only while waiting on a word
//   send_en        one-cycle pulse starting a UART word
//   data_byte_send word being transmitted, held until its Tx_Done
//   Busy           frame in progress
//   Frame_Done     pulse after the final word of a frame completes
//   Err_Timeout    pulse when a word gets no Tx_Done in time; the frame is retried after the gap
module sensor_cmd_seq #(
  parameter int                  DATA_W         = 8,
  parameter logic [DATA_W-1:0]   START_CMD      = 8'h8A,
  parameter logic [DATA_W-1:0]   STOP_CMD       = 8'h88,
  parameter int                  HDR_LEN        = 0,
  parameter logic [4*DATA_W-1:0] HDR_WORDS      = '0,
  parameter int                  GAP_CYCLES     = 16,
  parameter int                  TIMEOUT_CYCLES = 4096
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Sys_Start,
  input  logic              Tx_Done,
  output logic              send_en,
  output logic [DATA_W-1:0] data_byte_send,
  output logic              Busy,
  output logic              Frame_Done,
  output logic              Err_Timeout
);
`ifdef SENSOR_CMD_CHKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam logic [2:0] LAST = 3'(HDR_LEN + CK);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [2:0] {INIT, IDLE, SEND, WAIT, GAP} state_t;
  localparam state_t AFTER = (GAP_CYCLES == 0) ? IDLE : GAP;
  state_t            state;
  logic [1:0]        sync;
  logic              req;
  logic              init_done;
  logic              sent_valid;
  logic              sent_lvl;
  logic              cur_lvl;
  logic [2:0]        idx;
  logic [TW-1:0]     tcnt;
  logic [GW-1:0]     gcnt;
  logic [DATA_W-1:0] frame [8];
`ifdef SENSOR_CMD_CHKSUM_EN
  logic [DATA_W-1:0] chk;
`endif
  assign req = sync[1];
  // Word table for the current frame: header words, opcode, then checksum (or zero) slots.
  for (genvar g = 0; g < 8; g++) begin : g_frame
    if (g < HDR_LEN) begin : g_hdr
      assign frame[g] = HDR_WORDS[DATA_W*(HDR_LEN-1-g) +: DATA_W];
    end else if (g == HDR_LEN) begin : g_op
      assign frame[g] = cur_lvl ? START_CMD : STOP_CMD;
    end else begin : g_tail
`ifdef SENSOR_CMD_CHKSUM_EN
      assign frame[g] = chk;
`else
      assign frame[g] = '0;
`endif
    end
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state          <= INIT;
      sync           <= '0;
      init_done      <= 1'b0;
      sent_valid     <= 1'b0;
      sent_lvl       <= 1'b0;
      cur_lvl        <= 1'b0;
      idx            <= '0;
      tcnt           <= '0;
      gcnt           <= '0;
      send_en        <= 1'b0;
      data_byte_send <= '0;
      Busy           <= 1'b0;
      Frame_Done     <= 1'b0;
      Err_Timeout    <= 1'b0;
`ifdef SENSOR_CMD_CHKSUM_EN
      chk            <= '0;
`endif
    end else begin
      sync        <= {sync[0], Sys_Start};
      send_en     <= 1'b0;
      Frame_Done  <= 1'b0;
      Err_Timeout <= 1'b0;
      case (state)
        INIT: begin
          init_done <= 1'b1;
          if (init_done) state <= IDLE;
        end
        IDLE: if (!sent_valid || req != sent_lvl) begin
          cur_lvl <= req;
          idx     <= '0;
          Busy    <= 1'b1;
          state   <= SEND;
`ifdef SENSOR_CMD_CHKSUM_EN
          chk     <= '0;
`endif
        end
        SEND: begin
          send_en        <= 1'b1;
          data_byte_send <= frame[idx];
          tcnt           <= '0;
          state          <= WAIT;
`ifdef SENSOR_CMD_CHKSUM_EN
          chk            <= chk ^ frame[idx];
`endif
        end
        // Tx_Done is checked before expiry so a completion on the last allowed cycle still counts.
        WAIT: if (Tx_Done) begin
          if (idx == LAST) begin
            Busy       <= 1'b0;
            Frame_Done <= 1'b1;
            sent_valid <= 1'b1;
            sent_lvl   <= cur_lvl;
            gcnt       <= '0;
            state      <= AFTER;
          end else begin
            idx   <= idx + 3'd1;
            state <= SEND;
          end
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          Busy        <= 1'b0;
          Err_Timeout <= 1'b1;
          gcnt        <= '0;
          state       <= AFTER;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
        GAP: if (gcnt == GW'(GAP_CYCLES - 1)) state <= IDLE; else gcnt <= gcnt + 1'b1;
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_sensor_cmd_seq.sv
// tb_sensor_cmd_seq: directed checks of sensor_cmd_seq in default and header/timeout configurations
module tb_sensor_cmd_seq;
`ifdef SENSOR_CMD_CHKSUM_EN
  localparam int NW = 4;
`else
  localparam int NW = 3;
`endif
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic [1:0]      rst_n;
  logic [1:0]      sys_start;
  logic [1:0]      tx_done;
  logic [1:0]      send_en;
  logic [1:0][7:0] data;
  logic [1:0]      busy;
  logic [1:0]      fdone;
  logic [1:0]      etime;
  int checks = 0;
  int errors = 0;
  int waited;
  sensor_cmd_seq u_a (
    .Clk(Clk), .Rst_n(rst_n[0]), .Sys_Start(sys_start[0]), .Tx_Done(tx_done[0]),
    .send_en(send_en[0]), .data_byte_send(data[0]), .Busy(busy[0]),
    .Frame_Done(fdone[0]), .Err_Timeout(etime[0])
  );
  sensor_cmd_seq #(
    .HDR_LEN(2), .HDR_WORDS(32'h0000_55AA), .GAP_CYCLES(4), .TIMEOUT_CYCLES(8)
  ) u_b (
    .Clk(Clk), .Rst_n(rst_n[1]), .Sys_Start(sys_start[1]), .Tx_Done(tx_done[1]),
    .send_en(send_en[1]), .data_byte_send(data[1]), .Busy(busy[1]),
    .Frame_Done(fdone[1]), .Err_Timeout(etime[1])
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_word(input int u, input logic [7:0] exp, input string tag, output int w);
    w = 0;
    do begin
      @(negedge Clk);
      tx_done[u] = 1'b0;
      w++;
    end while (!send_en[u] && w < 60);
    chk({tag, "_send_en"}, send_en[u], 1);
    chk({tag, "_word"}, data[u], exp);
  endtask
  task automatic ack(input int u, input int n, input logic [7:0] exp, input string tag);
    for (int i = 1; i < n; i++) begin
      @(negedge Clk);
      chk({tag, "_hold"}, data[u], exp);
    end
    tx_done[u] = 1'b1;
  endtask
  task automatic end_frame(input int u, input string tag);
    @(negedge Clk);
    tx_done[u] = 1'b0;
    chk({tag, "_frame_done"}, fdone[u], 1);
    chk({tag, "_no_timeout"}, etime[u], 0);
    chk({tag, "_busy_low"}, busy[u], 0);
    @(negedge Clk);
    chk({tag, "_frame_done_pulse"}, fdone[u], 0);
  endtask
  task automatic quiet(input int u, input int n, input string tag);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (send_en[u]) cnt++;
    end
    chk(tag, cnt, 0);
  endtask
  task automatic frame_b(input logic [7:0] op, input bit glitch, input int start_k,
                         input string tag, output int first_wait);
    logic [7:0] w [4];
    int lat;
    w[0] = 8'h55;
    w[1] = 8'hAA;
    w[2] = op;
    w[3] = 8'h55 ^ 8'hAA ^ op;
    first_wait = 0;
    if (start_k == 1) ack(1, 3, w[0], tag);
    for (int k = start_k; k < NW; k++) begin
      send_word(1, w[k], tag, lat);
      if (k == start_k) first_wait = lat;
      else chk({tag, "_next_latency"}, lat, 2);
      if (glitch && k == 0) sys_start[1] = 1'b0;
      if (glitch && k == 1) sys_start[1] = 1'b1;
      ack(1, 3, w[k], tag);
    end
    end_frame(1, tag);
  endtask
  initial begin
    rst_n     = 2'b00;
    sys_start = 2'b10;
    tx_done   = 2'b00;
    repeat (3) @(negedge Clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_send_en", send_en[u], 0);
      chk("rst_data", data[u], 0);
      chk("rst_busy", busy[u], 0);
      chk("rst_frame_done", fdone[u], 0);
      chk("rst_err_timeout", etime[u], 0);
    end
    rst_n[0] = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge Clk);
      chk("a_pre_send", send_en[0], 0);
    end
    @(negedge Clk);
    chk("a_edge4_send", send_en[0], 1);
    chk("a_first_word", data[0], 8'h88);
    chk("a_busy", busy[0], 1);
    ack(0, 10, 8'h88, "a_stop0");
    end_frame(0, "a_stop0");
    quiet(0, 40, "a_silence");
    sys_start[0] = 1'b1;
    send_word(0, 8'h8A, "a_start", waited);
    chk("a_start_latency", waited, 4);
    ack(0, 10, 8'h8A, "a_start");
    end_frame(0, "a_start");
    sys_start[0] = 1'b0;
    send_word(0, 8'h88, "a_stop", waited);
    chk("a_stop_after_gap", waited, 17);
    ack(0, 10, 8'h88, "a_stop");
    end_frame(0, "a_stop");
    rst_n[1] = 1'b1;
    frame_b(8'h8A, 1'b1, 0, "b_start", waited);
    chk("b_start_latency", waited, 4);
    quiet(1, 30, "b_glitch_no_extra");
    sys_start[1] = 1'b0;
    frame_b(8'h88, 1'b0, 0, "b_stop", waited);
    quiet(1, 20, "b_stop_settled");
    sys_start[1] = 1'b1;
    send_word(1, 8'h55, "b_to", waited);
    for (int i = 1; i < 8; i++) begin
      @(negedge Clk);
      chk("b_to_early", etime[1], 0);
    end
    @(negedge Clk);
    chk("b_to_pulse", etime[1], 1);
    chk("b_to_no_frame_done", fdone[1], 0);
    chk("b_to_busy_low", busy[1], 0);
    send_word(1, 8'h55, "b_retry1", waited);
    chk("b_retry1_gap", waited, 6);
    repeat (8) @(negedge Clk);
    chk("b_to_pulse2", etime[1], 1);
    send_word(1, 8'h55, "b_retry2", waited);
    chk("b_retry2_gap", waited, 6);
    frame_b(8'h8A, 1'b0, 1, "b_retry_done", waited);
    chk("b_retry_next_latency", waited, 2);
    quiet(1, 20, "b_retry_settled");
    sys_start[1] = 1'b0;
    send_word(1, 8'h55, "b_rs0", waited);
    ack(1, 3, 8'h55, "b_rs0");
    send_word(1, 8'hAA, "b_rs1", waited);
    @(negedge Clk);
    rst_n[1] = 1'b0;
    #1;
    chk("b_rs_send_en", send_en[1], 0);
    chk("b_rs_data", data[1], 0);
    chk("b_rs_busy", busy[1], 0);
    chk("b_rs_frame_done", fdone[1], 0);
    chk("b_rs_err_timeout", etime[1], 0);
    repeat (2) @(negedge Clk);
    tx_done[1] = 1'b0;
    rst_n[1] = 1'b1;
    frame_b(8'h88, 1'b0, 0, "b_resend", waited);
    chk("b_resend_latency", waited, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sensor_cmd_seq.md
# sensor_cmd_seq

Parametrised command sequencer between system control and the sensor-link UART transmitter. It tracks the level of `Sys_Start` and emits a start or stop command frame on every settled level change. A frame is an optional header, an opcode and an optional checksum. Each byte is handed to the UART with a `send_en`/`Tx_Done` handshake, and a per-byte timeout and retry path is provided.

## Interface
- `DATA_W`, 8, width of each frame word and of the UART data port.
- `START_CMD`, 8'h8A, opcode sent when `Sys_Start` is 1.
- `STOP_CMD`, 8'h88, opcode sent when `Sys_Start` is 0.
- `HDR_LEN`, 0, number of header words, range 0..4.
- `HDR_WORDS`, 0, packed header of 4*`DATA_W` bits; word k is `HDR_WORDS[DATA_W*(HDR_LEN-1-k) +: DATA_W]`, sent first-to-last.
- `GAP_CYCLES`, 16, idle cycles after each frame end or abort before the next decision; 0 means no gap.
- `TIMEOUT_CYCLES`, 4096, cycles allowed from `send_en` to `Tx_Done`; must be at least 1.

Ports:
- `Clk`, input, 1, system clock.
- `Rst_n`, input, 1, reset; asynchronous assert, active-low.
- `Sys_Start`, input, 1, requested sensor run state; asynchronous, level.
- `Tx_Done`, input, 1, one-cycle pulse from the UART when the current word has left.
- `send_en`, output, 1, one-cycle pulse that starts a UART word.
- `data_byte_send`, output, `DATA_W`, word to transmit; stable from the `send_en` cycle until the `Tx_Done` cycle.
- `Busy`, output, 1, high while a frame is in progress (SEND or WAIT).
- `Frame_Done`, output, 1, one-cycle pulse after the final word's `Tx_Done`.
- `Err_Timeout`, output, 1, one-cycle pulse when a word times out.

## Operation
- `Sys_Start` passes through a 2-flop synchroniser; the synchronised value is `req`.
- Register `sent_valid` clears on reset. Register `sent_lvl` holds the level of the last successfully completed frame.
- States:
  - INIT: 2 cycles, so the synchroniser fills; then go to IDLE.
  - IDLE: if `!sent_valid || req != sent_lvl`, capture `cur_lvl <= req`, set word index 0, go to SEND.
  - SEND: assert `send_en` with the current word; go to WAIT.
  - WAIT: on `Tx_Done`, if this was the last word, go to GAP, set `sent_valid`, `sent_lvl <= cur_lvl` and pulse `Frame_Done`; otherwise increment the index and go to SEND. On timeout, pulse `Err_Timeout`, go to GAP and leave `sent_*` unchanged, so the frame is retried in full.
  - GAP: count `GAP_CYCLES`, then go to IDLE.
- Frame sequence: header words 0..`HDR_LEN`-1, then `cur_lvl ? START_CMD : STOP_CMD`, then the checksum if enabled. Frame length is `HDR_LEN`+1 (+1 with checksum).
- A `req` change during a frame does not alter that frame. It is re-evaluated in IDLE after the gap, so a 1→0→1 glitch inside a start frame sends nothing further.
- `Tx_Done` is ignored outside WAIT, including in the SEND cycle itself.
- Reset mid-frame: all outputs and state return to reset values immediately. The frame is abandoned and re-sent for the then-current level after INIT.
- Reset values: `send_en`=0, `data_byte_send`=0, `Busy`=0, `Frame_Done`=0, `Err_Timeout`=0, state=INIT, `sent_valid`=0.

## Timing
- `Rst_n` rises: INIT for 2 cycles, IDLE for 1, then `send_en` is high on the 4th rising edge after release.
- Settled `Sys_Start` change with the block idle: `send_en` rises 4 edges after the first edge that samples the new level (2 synchroniser edges, 1 IDLE edge, 1 SEND edge).
- Consecutive words in a frame: `send_en` follows `Tx_Done` by 2 edges (WAIT→SEND, then SEND).
- The timeout counter starts at 0 in the SEND cycle. Expiry occurs in the WAIT cycle where the count reaches `TIMEOUT_CYCLES` with no `Tx_Done`. `Tx_Done` in that same cycle wins.
- `Frame_Done` is high in the cycle after the last `Tx_Done`. `Busy` falls in that same cycle.
- `Frame_Done` and `Err_Timeout` are never high together.

## Configuration
- `SENSOR_CMD_CHKSUM_EN` defined: a final word equal to the XOR of all preceding frame words (header and opcode) is appended.
  - Example: `HDR_LEN`=1, header 8'hAA, start opcode: words AA, 8A, 20.
- `SENSOR_CMD_CHKSUM_EN` undefined: no checksum word and no XOR logic; the frame ends at the opcode.

## Test plan
- Defaults, `Sys_Start`=0 through reset, `Tx_Done` returned 10 cycles after each `send_en`: one word 88 with `send_en` on edge 4 after reset, `Frame_Done` once, then silence.
- Raise `Sys_Start` while idle: word 8A. Drop it: word 88. Each frame is one `send_en`, followed by a 16-cycle gap.
- `HDR_LEN`=2, `HDR_WORDS`=32'h0000_55AA, checksum enabled, start request: words 55, AA, 8A, 75 in order, with `data_byte_send` stable during each WAIT.
- Toggle `Sys_Start` 1→0→1 within one start frame: no extra frame. Toggle 1→0 and hold: one stop frame after the gap.
- `TIMEOUT_CYCLES`=8, never return `Tx_Done`: `Err_Timeout` pulses 8 cycles after `send_en`, with the same frame retried after each gap. Then return `Tx_Done`: `Frame_Done` pulses, and `Err_Timeout` stays low.
- Pull `Rst_n` low during word 2 of a 3-word frame: all outputs go to 0 at once. After release, the full frame is re-sent from word 0.
